// File: rtl/ecg_acc_pkg.sv
// Shared constants and types for the ECG accelerator datapath.
// Used by the output register file, max_pool_pack and the writeback block.
//   DATA_W / WIN_BYTES / PACK : element width, window length, lanes per word
//   P_LEN_*                   : the legal pooling window lengths
//   lane_mask_t               : one valid bit per packed lane
package ecg_acc_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned WIN_BYTES = 7;
  localparam int unsigned PACK      = 4;

  localparam logic [2:0] P_LEN_2 = 3'd2;
  localparam logic [2:0] P_LEN_4 = 3'd4;
  localparam logic [2:0] P_LEN_5 = 3'd5;
  localparam logic [2:0] P_LEN_7 = 3'd7;

  typedef logic [PACK-1:0] lane_mask_t;

  function automatic logic p_is_legal(input logic [2:0] p);
    return (p == P_LEN_2) || (p == P_LEN_4) || (p == P_LEN_5) || (p == P_LEN_7);
  endfunction

endpackage

// File: rtl/max_pool_pack_pk_fifo.sv
// pk_fifo: synchronous show-ahead FIFO.
//   clk/rst          : clock, synchronous active-high reset
//   i_push / i_data  : write strobe and word
//   i_pop            : pop the head (ignored when empty)
//   o_data           : head word, all zeros while empty
//   o_full / o_empty : occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
module pk_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop_ok  = i_pop && !o_empty;
  // When full, the slot being written is the one being popped this cycle.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/max_pool_pack.sv
// max_pool_pack: max-pooling (kernel P) over sliding windows, packing four
// pooled bytes per 32-bit word into a show-ahead FIFO drained by valid/ready.
//   clk_cal, rst_cal : clock, synchronous active-high reset
//   pool_p           : window length (2, 4, 5 or 7)
//   win_data/win_vld : window bytes (byte 0 oldest) and strobe
//   layer_end        : end-of-layer pulse, flushes a partial word or a marker
//   pk_data/pk_bmask/pk_last/pk_vld/pk_rdy : packed output handshake
//   ovf_err, cfg_err : sticky overflow / illegal-P flags
// Macro MAX_POOL_RELU_EN: clamp negative pooled values to zero.
module max_pool_pack
  import ecg_acc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_cal,
  input  logic        rst_cal,
  input  logic [2:0]  pool_p,
  input  logic [55:0] win_data,
  input  logic        win_vld,
  input  logic        layer_end,
  output logic [31:0] pk_data,
  output logic [3:0]  pk_bmask,
  output logic        pk_last,
  output logic        pk_vld,
  input  logic        pk_rdy,
  output logic        ovf_err,
  output logic        cfg_err
);

  localparam int unsigned WORD_W = 32 + PACK + 1;

  function automatic logic signed [DATA_W-1:0] win_max(input logic [55:0] win,
                                                       input logic [2:0]  p);
    logic signed [DATA_W-1:0] m;
    logic signed [DATA_W-1:0] b;
    m = win[DATA_W-1:0];
    for (int unsigned i = 1; i < WIN_BYTES; i++) begin
      b = win[i*DATA_W +: DATA_W];
      if ((i < {29'd0, p}) && (b > m)) m = b;
    end
    return m;
  endfunction

  // Input capture
  logic [2:0]  r_p_in;
  logic [55:0] r_win;
  logic        r_win_vld;
  logic        r_end_in;

  // Reduce stage
  logic signed [DATA_W-1:0] w_max;
  logic signed [DATA_W-1:0] w_max_out;
  logic signed [DATA_W-1:0] r_max_q;
  logic                     r_max_v;
  logic                     r_end_q;
  logic                     r_cfg_err;

  // Pack stage
  logic [1:0]        r_lane_cnt;
  logic [31:0]       r_acc;
  logic [31:0]       w_word;
  logic [2:0]        w_fill;
  lane_mask_t        w_mask;
  logic              w_push;
  logic [WORD_W-1:0] w_head;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              r_ovf_err;

  assign w_max = win_max(r_win, r_p_in);
`ifdef MAX_POOL_RELU_EN
  assign w_max_out = w_max[DATA_W-1] ? '0 : w_max;
`else
  assign w_max_out = w_max;
`endif

  always_ff @(posedge clk_cal) begin
    if (rst_cal) begin
      r_p_in    <= '0;
      r_win     <= '0;
      r_win_vld <= 1'b0;
      r_end_in  <= 1'b0;
      r_max_q   <= '0;
      r_max_v   <= 1'b0;
      r_end_q   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_p_in    <= pool_p;
      r_win     <= win_data;
      r_win_vld <= win_vld;
      r_end_in  <= layer_end;
      r_max_q   <= w_max_out;
      r_max_v   <= r_win_vld && p_is_legal(r_p_in);
      r_end_q   <= r_end_in;
      if (r_win_vld && !p_is_legal(r_p_in)) r_cfg_err <= 1'b1;
    end
  end

  // Accumulator with this cycle's byte merged in; lanes not yet written stay
  // zero because the accumulator is cleared on every push.
  always_comb begin
    w_word = r_acc;
    if (r_max_v) w_word[{r_lane_cnt, 3'b000} +: 8] = r_max_q;
  end

  assign w_fill = {1'b0, r_lane_cnt} + {2'b00, r_max_v};
  // A full word and a flush in the same cycle collapse into one push with last=1.
  assign w_push = (w_fill == 3'd4) || r_end_q;

  always_comb begin
    case (w_fill)
      3'd0:    w_mask = 4'b0000;
      3'd1:    w_mask = 4'b0001;
      3'd2:    w_mask = 4'b0011;
      3'd3:    w_mask = 4'b0111;
      default: w_mask = 4'b1111;
    endcase
  end

  always_ff @(posedge clk_cal) begin
    if (rst_cal) begin
      r_lane_cnt <= '0;
      r_acc      <= '0;
      r_ovf_err  <= 1'b0;
    end else begin
      if (w_push) begin
        r_lane_cnt <= '0;
        r_acc      <= '0;
      end else if (r_max_v) begin
        r_lane_cnt <= r_lane_cnt + 1'b1;
        r_acc      <= w_word;
      end
      if (w_push && w_fifo_full && !pk_rdy) r_ovf_err <= 1'b1;
    end
  end

  pk_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_cal),
    .rst     (rst_cal),
    .i_push  (w_push),
    .i_data  ({w_word, w_mask, r_end_q}),
    .i_pop   (pk_rdy),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign pk_data  = w_head[WORD_W-1 -: 32];
  assign pk_bmask = w_head[PACK:1];
  assign pk_last  = w_head[0];
  assign pk_vld   = !w_fifo_empty;
  assign ovf_err  = r_ovf_err;
  assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_max_pool_pack.sv
// Directed self-checking bench for max_pool_pack.
module tb_max_pool_pack;

  logic        clk_cal = 1'b0;
  logic        rst_cal;
  logic [2:0]  pool_p;
  logic [55:0] win_data;
  logic        win_vld;
  logic        layer_end;
  logic [31:0] pk_data;
  logic [3:0]  pk_bmask;
  logic        pk_last;
  logic        pk_vld;
  logic        pk_rdy;
  logic        ovf_err;
  logic        cfg_err;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  max_pool_pack #(.FIFO_DEPTH(4)) dut (
    .clk_cal   (clk_cal),
    .rst_cal   (rst_cal),
    .pool_p    (pool_p),
    .win_data  (win_data),
    .win_vld   (win_vld),
    .layer_end (layer_end),
    .pk_data   (pk_data),
    .pk_bmask  (pk_bmask),
    .pk_last   (pk_last),
    .pk_vld    (pk_vld),
    .pk_rdy    (pk_rdy),
    .ovf_err   (ovf_err),
    .cfg_err   (cfg_err)
  );

  always #5 clk_cal = ~clk_cal;

  typedef struct {
    logic [2:0]  p;
    logic [55:0] win;
    logic [7:0]  raw_max;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk_cal);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Window strobe (optionally with layer_end) held for exactly one edge.
  task automatic send(input logic [55:0] w, input logic v, input logic e);
    win_data  = w;
    win_vld   = v;
    layer_end = e;
    tick();
    win_vld   = 1'b0;
    layer_end = 1'b0;
  endtask

  task automatic pop();
    pk_rdy = 1'b1;
    tick();
    pk_rdy = 1'b0;
  endtask

  function automatic logic [55:0] fill(input logic [7:0] b);
    return {7{b}};
  endfunction

  function automatic logic [63:0] head();
    return {26'd0, pk_vld, pk_last, pk_bmask, pk_data};
  endfunction

  function automatic logic [63:0] mk(input logic v, input logic l, input logic [3:0] m,
                                     input logic [31:0] d);
    return {26'd0, v, l, m, d};
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  exp_b;
    logic [31:0] exp_w;

    vecs[0] = '{p: 3'd2, win: 56'h0000000000_7FFE80 | 56'h0, raw_max: 8'hFE};
    vecs[1] = '{p: 3'd4, win: 56'h00000001_7FF005,  raw_max: 8'h7F};
    vecs[2] = '{p: 3'd5, win: 56'h7F7F9083828180,   raw_max: 8'h90};
    vecs[3] = '{p: 3'd7, win: 56'hFF868584838281,   raw_max: 8'hFF};
    vecs[4] = '{p: 3'd7, win: 56'h7E504030201000,   raw_max: 8'h7E};
    vecs[5] = '{p: 3'd4, win: 56'h7F7F7FC0808080,   raw_max: 8'hC0};
    vecs[6] = '{p: 3'd2, win: 56'h0000000000807F,   raw_max: 8'h7F};

    rst_cal = 1'b1; pool_p = 3'd4; win_data = '0; win_vld = 1'b0;
    layer_end = 1'b0; pk_rdy = 1'b0;
    tick(); tick();
    rst_cal = 1'b0;
    chk("reset_state", {head(), ovf_err, cfg_err}, '0);

    // Single window + layer_end: one partial word holding just the pooled byte.
    for (int i = 0; i < 7; i++) begin
      exp_b = vecs[i].raw_max;
`ifdef MAX_POOL_RELU_EN
      if (exp_b[7]) exp_b = 8'h00;
`endif
      pool_p = vecs[i].p;
      send(vecs[i].win, 1'b1, 1'b1);
      tick(); tick();
      chk($sformatf("vec%0d_word", i), head(), mk(1'b1, 1'b1, 4'b0001, {24'd0, exp_b}));
      pop();
      chk($sformatf("vec%0d_drained", i), head(), '0);
    end

    // Basic pooling with consumer always ready; latency check.
    pool_p = 3'd4;
    pk_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send(56'h00000001_7FF005, 1'b1, 1'b0);
    tick();
    chk("basic_not_yet", {63'd0, pk_vld}, 64'd0);
    tick();
    chk("basic_word", head(), mk(1'b1, 1'b0, 4'b1111, 32'h7F7F7F7F));
    tick();
    chk("basic_popped", {63'd0, pk_vld}, 64'd0);
    pk_rdy = 1'b0;

    // Partial flush followed by an immediate second layer_end (marker).
    pool_p = 3'd7;
    send(fill(8'h11), 1'b1, 1'b0);
    send(fill(8'h22), 1'b1, 1'b0);
    send(fill(8'h33), 1'b1, 1'b0);
    send('0, 1'b0, 1'b1);
    send('0, 1'b0, 1'b1);
    tick();
    chk("partial_word", head(), mk(1'b1, 1'b1, 4'b0111, 32'h00332211));
    tick();
    pop();
    chk("marker_word", head(), mk(1'b1, 1'b1, 4'b0000, 32'h0));
    pop();
    chk("marker_drained", {63'd0, pk_vld}, 64'd0);

    // Fourth window coincides with layer_end: one full word, last=1, no marker.
    pool_p = 3'd4;
    send(fill(8'h01), 1'b1, 1'b0);
    send(fill(8'h02), 1'b1, 1'b0);
    send(fill(8'h03), 1'b1, 1'b0);
    send(fill(8'h04), 1'b1, 1'b1);
    tick(); tick();
    chk("coincide_word", head(), mk(1'b1, 1'b1, 4'b1111, 32'h04030201));
    pop();
    chk("coincide_no_marker", {63'd0, pk_vld}, 64'd0);
    tick();
    chk("coincide_no_marker2", {63'd0, pk_vld}, 64'd0);

    // Backpressure: 5 words into a 4-deep FIFO, fifth dropped.
    pool_p = 3'd5;
    for (int k = 1; k <= 20; k++) send(fill(8'(k)), 1'b1, 1'b0);
    tick(); tick();
    chk("ovf_set", {63'd0, ovf_err}, 64'd1);
    chk("bp_head", head(), mk(1'b1, 1'b0, 4'b1111, 32'h04030201));
    tick();
    chk("bp_head_stable", head(), mk(1'b1, 1'b0, 4'b1111, 32'h04030201));
    pk_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) exp_w[j*8 +: 8] = 8'(4*k + j + 1);
      chk($sformatf("drain%0d", k), head(), mk(1'b1, 1'b0, 4'b1111, exp_w));
      tick();
    end
    chk("drain_empty", {63'd0, pk_vld}, 64'd0);
    pk_rdy = 1'b0;

    // Illegal P: cfg_err set and the window does not occupy a lane.
    pool_p = 3'd3;
    send(fill(8'h55), 1'b1, 1'b0);
    tick();
    chk("cfg_set", {63'd0, cfg_err}, 64'd1);
    pool_p = 3'd4;
    for (int k = 0; k < 4; k++) send(fill(8'(8'h60 + k)), 1'b1, 1'b0);
    tick(); tick();
    chk("cfg_no_lane", head(), mk(1'b1, 1'b0, 4'b1111, 32'h63626160));
    for (int k = 0; k < 4; k++) send(fill(8'(8'h70 + k)), 1'b1, 1'b0);
    tick(); tick();
    chk("errs_sticky", {62'd0, ovf_err, cfg_err}, 64'd3);

    // Reset with two words queued.
    rst_cal = 1'b1;
    tick();
    rst_cal = 1'b0;
    chk("reset_mid", {head(), ovf_err, cfg_err}, '0);
    tick(); tick();
    chk("reset_no_flush", {63'd0, pk_vld}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
